memory_responder: RTL and testbench

Responder end of the memory accessor protocol: accepts read and write requests from an initiator (CPU fetch/load-store unit), services them from an internal 16-bit-wide word array after a configurable number of wait states, and pulses `read_ready`/`write_ready` to complete each transfer. Read and write channels are independent and may be active at the same time. Sits between the core's memory accessor and the on-chip RAM, acting as the main memory model for the risc1 design.

---
 rtl/memory_responder.sv | 175 +++++++++++++++++
 tb/tb_memory_responder.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Responder end of the memory accessor protocol: 16-bit word array with independent read/write channels.
// Define MEMORY_WAIT_STATES_EN to honour READ_LATENCY/WRITE_LATENCY; otherwise every transfer completes in one cycle.
module memory_responder #(
  parameter int ARCH_SIZE     = 16,
  parameter int ADDR_BITS     = 10,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read,
  input  logic [ARCH_SIZE-1:0] read_address,
  output logic                 read_ready,
  output logic [15:0]          read_value,
  input  logic                 write,
  input  logic [ARCH_SIZE-1:0] write_address,
  input  logic [15:0]          write_value,
  output logic                 write_ready
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                 rd_state_q, rd_state_d;
  state_e                 wr_state_q, wr_state_d;
  logic [ADDR_BITS-1:0]   rd_idx_q, rd_idx_d;
  logic [ADDR_BITS-1:0]   wr_idx_q, wr_idx_d;
  logic [15:0]            wr_data_q, wr_data_d;
  logic [15:0]            read_value_q, read_value_d;
  logic                   read_ready_q, read_ready_d;
  logic                   write_ready_q, write_ready_d;
  logic                   rd_commit, wr_commit;
  logic [15:0]            mem [DEPTH];
  logic                   unused_ok;

`ifdef MEMORY_WAIT_STATES_EN
  localparam logic [3:0] RL = 4'(READ_LATENCY);
  localparam logic [3:0] WL = 4'(WRITE_LATENCY);
  logic [3:0] rd_cnt_q, rd_cnt_d;
  logic [3:0] wr_cnt_q, wr_cnt_d;
  assign unused_ok = ^{read_address[ARCH_SIZE-1:ADDR_BITS],
                       write_address[ARCH_SIZE-1:ADDR_BITS]};
`else
  assign unused_ok = ^{read_address[ARCH_SIZE-1:ADDR_BITS],
                       write_address[ARCH_SIZE-1:ADDR_BITS],
                       4'(READ_LATENCY), 4'(WRITE_LATENCY)};
`endif

  // Counter holds latency-1 so RESP lands exactly LATENCY cycles after acceptance.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_idx_d   = rd_idx_q;
    rd_commit  = 1'b0;
`ifdef MEMORY_WAIT_STATES_EN
    rd_cnt_d   = rd_cnt_q;
`endif
    unique case (rd_state_q)
      S_IDLE: if (read) begin
        rd_idx_d = read_address[ADDR_BITS-1:0];
`ifdef MEMORY_WAIT_STATES_EN
        if (RL == 4'd0) begin
          rd_state_d = S_RESP;
          rd_commit  = 1'b1;
        end else begin
          rd_cnt_d   = RL - 4'd1;
          rd_state_d = S_WAIT;
        end
`else
        rd_state_d = S_RESP;
        rd_commit  = 1'b1;
`endif
      end
`ifdef MEMORY_WAIT_STATES_EN
      S_WAIT: begin
        if (rd_cnt_q == 4'd0) begin
          rd_state_d = S_RESP;
          rd_commit  = 1'b1;
        end else begin
          rd_cnt_d = rd_cnt_q - 4'd1;
        end
      end
`endif
      default: rd_state_d = S_IDLE;
    endcase
    read_value_d = rd_commit ? mem[rd_idx_d] : read_value_q;
    read_ready_d = (rd_state_d == S_RESP);
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_idx_d   = wr_idx_q;
    wr_data_d  = wr_data_q;
    wr_commit  = 1'b0;
`ifdef MEMORY_WAIT_STATES_EN
    wr_cnt_d   = wr_cnt_q;
`endif
    unique case (wr_state_q)
      S_IDLE: if (write) begin
        wr_idx_d  = write_address[ADDR_BITS-1:0];
        wr_data_d = write_value;
`ifdef MEMORY_WAIT_STATES_EN
        if (WL == 4'd0) begin
          wr_state_d = S_RESP;
          wr_commit  = 1'b1;
        end else begin
          wr_cnt_d   = WL - 4'd1;
          wr_state_d = S_WAIT;
        end
`else
        wr_state_d = S_RESP;
        wr_commit  = 1'b1;
`endif
      end
`ifdef MEMORY_WAIT_STATES_EN
      S_WAIT: begin
        if (wr_cnt_q == 4'd0) begin
          wr_state_d = S_RESP;
          wr_commit  = 1'b1;
        end else begin
          wr_cnt_d = wr_cnt_q - 4'd1;
        end
      end
`endif
      default: wr_state_d = S_IDLE;
    endcase
    write_ready_d = (wr_state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q    <= S_IDLE;
      wr_state_q    <= S_IDLE;
      rd_idx_q      <= '0;
      wr_idx_q      <= '0;
      wr_data_q     <= '0;
      read_value_q  <= '0;
      read_ready_q  <= 1'b0;
      write_ready_q <= 1'b0;
`ifdef MEMORY_WAIT_STATES_EN
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
`endif
    end else begin
      rd_state_q    <= rd_state_d;
      wr_state_q    <= wr_state_d;
      rd_idx_q      <= rd_idx_d;
      wr_idx_q      <= wr_idx_d;
      wr_data_q     <= wr_data_d;
      read_value_q  <= read_value_d;
      read_ready_q  <= read_ready_d;
      write_ready_q <= write_ready_d;
`ifdef MEMORY_WAIT_STATES_EN
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
`endif
    end
  end

  // Nonblocking update gives read-before-write on a same-edge collision.
  always_ff @(posedge clk) begin
    if (wr_commit && !reset) begin
      mem[wr_idx_d] <= wr_data_d;
    end
  end

  assign read_ready  = read_ready_q;
  assign read_value  = read_value_q;
  assign write_ready = write_ready_q;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed scenarios plus randomized traffic against a word-array model.
// Expected latencies follow MEMORY_WAIT_STATES_EN the same way the design does.
module tb_memory_responder;

  localparam int ARCH  = 16;
  localparam int AB    = 10;
  localparam int DEPTH = 1 << AB;
`ifdef MEMORY_WAIT_STATES_EN
  localparam int RL = 2;
  localparam int WL = 1;
`else
  localparam int RL = 0;
  localparam int WL = 0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            read;
  logic [ARCH-1:0] read_address;
  logic            read_ready;
  logic [15:0]     read_value;
  logic            write;
  logic [ARCH-1:0] write_address;
  logic [15:0]     write_value;
  logic            write_ready;

  int checks = 0;
  int failures = 0;

  logic [15:0] model [DEPTH];
  int          written[$];

  memory_responder #(
    .ARCH_SIZE(ARCH),
    .ADDR_BITS(AB),
    .READ_LATENCY(2),
    .WRITE_LATENCY(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .read(read),
    .read_address(read_address),
    .read_ready(read_ready),
    .read_value(read_value),
    .write(write),
    .write_address(write_address),
    .write_value(write_value),
    .write_ready(write_ready)
  );

  always #5 clk = ~clk;

  // Drivers: start and end at 1ns after a rising edge with the channel idle.
  task automatic do_read(input logic [ARCH-1:0] a,
                         output int lat, output logic [15:0] v);
    lat = -1;
    v = 16'hxxxx;
    read = 1'b1;
    read_address = a;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (read_ready) begin
        lat = k;
        v = read_value;
        break;
      end
    end
    read = 1'b0;
    read_address = $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ARCH-1:0] a, input logic [15:0] d,
                          output int lat);
    lat = -1;
    write = 1'b1;
    write_address = a;
    write_value = d;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      write_address = $urandom;
      write_value = $urandom;
      if (write_ready) begin
        lat = k;
        break;
      end
    end
    write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (read_ready !== 1'b0 || write_ready !== 1'b0 || read_value !== 16'h0000) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got rr=%b wr=%b rv=%h want 0 0 0000",
                 i, read_ready, write_ready, read_value);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_write_read();
    int lat;
    logic [15:0] v;
    do_write(16'd5, 16'hBEEF, lat);
    model[5] = 16'hBEEF;
    written.push_back(5);
    checks++;
    if (lat !== WL + 1) begin
      failures++;
      $display("FAIL write_latency got %0d want %0d", lat, WL + 1);
    end
    do_read(16'd5, lat, v);
    checks++;
    if (lat !== RL + 1) begin
      failures++;
      $display("FAIL read_latency got %0d want %0d", lat, RL + 1);
    end
    checks++;
    if (v !== 16'hBEEF) begin
      failures++;
      $display("FAIL read_data got %h want beef", v);
    end
  endtask

  task automatic test_alias();
    int lat;
    logic [15:0] v;
    do_write(16'(DEPTH + 3), 16'h1234, lat);
    model[3] = 16'h1234;
    written.push_back(3);
    do_read(16'd3, lat, v);
    checks++;
    if (v !== 16'h1234 || lat !== RL + 1) begin
      failures++;
      $display("FAIL alias got %h lat %0d want 1234 lat %0d", v, lat, RL + 1);
    end
  endtask

  task automatic test_collision();
    int lat_r, lat_w;
    logic [15:0] v;
    int rd_dly, wr_dly;
    do_write(16'd7, 16'h0001, lat_w);
    rd_dly = (RL >= WL) ? 0 : WL - RL;
    wr_dly = (RL >= WL) ? RL - WL : 0;
    fork
      begin
        repeat (rd_dly) @(posedge clk);
        if (rd_dly > 0) #1;
        do_read(16'd7, lat_r, v);
      end
      begin
        repeat (wr_dly) @(posedge clk);
        if (wr_dly > 0) #1;
        do_write(16'd7, 16'h0002, lat_w);
      end
    join
    model[7] = 16'h0002;
    written.push_back(7);
    checks++;
    if (v !== 16'h0001) begin
      failures++;
      $display("FAIL collision_old got %h want 0001", v);
    end
    do_read(16'd7, lat_r, v);
    checks++;
    if (v !== 16'h0002) begin
      failures++;
      $display("FAIL collision_new got %h want 0002", v);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int per;
    int pulses;
    logic [15:0] d;
    logic exp_rr;
    d = 16'($urandom);
    do_write(16'd9, d, lat);
    model[9] = d;
    written.push_back(9);
    per = RL + 2;
    pulses = 0;
    read = 1'b1;
    read_address = 16'd9;
    for (int k = 1; k <= 4 * per; k++) begin
      @(posedge clk);
      #1;
      exp_rr = (k >= RL + 1) && ((k - RL - 1) % per == 0);
      checks++;
      if (read_ready !== exp_rr) begin
        failures++;
        $display("FAIL b2b_ready cyc=%0d got %b want %b", k, read_ready, exp_rr);
      end
      if (read_ready === 1'b1) begin
        pulses++;
        checks++;
        if (read_value !== d) begin
          failures++;
          $display("FAIL b2b_data cyc=%0d got %h want %h", k, read_value, d);
        end
      end
    end
    read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pulses != 4) begin
      failures++;
      $display("FAIL b2b_count got %0d want 4", pulses);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    logic [15:0] v;
    do_write(16'd4, 16'h5555, lat);
    model[4] = 16'h5555;
    written.push_back(4);
`ifdef MEMORY_WAIT_STATES_EN
    write = 1'b1;
    write_address = 16'd4;
    write_value = 16'hAAAA;
    @(posedge clk);
    #1;
    reset = 1'b1;
    write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (write_ready !== 1'b0) begin
        failures++;
        $display("FAIL abort_ready cyc=%0d got %b want 0", i, write_ready);
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    do_read(16'd4, lat, v);
    checks++;
    if (v !== 16'h5555) begin
      failures++;
      $display("FAIL abort_data got %h want 5555", v);
    end
`else
    read = 1'b1;
    read_address = 16'd4;
    @(posedge clk);
    #1;
    read = 1'b0;
    checks++;
    if (read_ready !== 1'b1 || read_value !== 16'h5555) begin
      failures++;
      $display("FAIL resp_pre_reset got rr=%b rv=%h want 1 5555", read_ready, read_value);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (read_ready !== 1'b0 || read_value !== 16'h0000) begin
      failures++;
      $display("FAIL resp_reset got rr=%b rv=%h want 0 0000", read_ready, read_value);
    end
`endif
  endtask

  task automatic test_random();
    int lat;
    int idx;
    logic [15:0] v, d;
    logic [ARCH-1:0] a;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        a = 16'($urandom);
        d = 16'($urandom);
        do_write(a, d, lat);
        idx = int'(a) % DEPTH;
        model[idx] = d;
        written.push_back(idx);
        checks++;
        if (lat !== WL + 1) begin
          failures++;
          $display("FAIL rand_wlat n=%0d got %0d want %0d", n, lat, WL + 1);
        end
      end else begin
        idx = written[$urandom_range(0, written.size() - 1)];
        a = 16'(idx + DEPTH * $urandom_range(0, (1 << (ARCH - AB)) - 1));
        do_read(a, lat, v);
        checks++;
        if (lat !== RL + 1 || v !== model[idx]) begin
          failures++;
          $display("FAIL rand_read n=%0d addr=%h got %h lat %0d want %h lat %0d",
                   n, a, v, lat, model[idx], RL + 1);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    read = 1'b0;
    write = 1'b0;
    read_address = '0;
    write_address = '0;
    write_value = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_alias();
    test_collision();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
